// File: rtl/condicionador_botoes.sv
// Button conditioner: 2-flop sync, per-channel debounce, press pulses,
// and auto-repeat on the increment channel.
//   state  | meaning
//   IDLE   | inc level low, waiting for a press
//   DELAY  | held, counting towards the first auto-repeat (held at expiry if repeat off)
//   REPEAT | held, emitting a pulse every REPEAT_PERIOD cycles
module condicionador_botoes #(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int REPEAT_DELAY    = 500000,
    parameter int REPEAT_PERIOD   = 150000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_ajuste_raw,
    input  logic btn_inc_raw,
    input  logic repeat_en,
    output logic btn_ajuste,
    output logic btn_inc,
    output logic nivel_ajuste,
    output logic nivel_inc
);
    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX);
    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} inc_state_t;

    // bit 0 = adjust channel, bit 1 = increment channel
    logic [1:0] sync_meta;
    logic [1:0] sync_s;
    logic [1:0] nivel;
    logic [1:0] db_flip;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_meta <= '0;
            sync_s    <= '0;
        end else begin
            sync_meta <= {btn_inc_raw, btn_ajuste_raw};
            sync_s    <= sync_meta;
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_db
        logic [DB_W-1:0] cnt;
        logic            lvl;

        assign db_flip[i] = (sync_s[i] != lvl) && (cnt == DB_LAST);
        assign nivel[i]   = lvl;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt <= '0;
                lvl <= 1'b0;
            end else if (db_flip[i]) begin
                cnt <= '0;
                lvl <= ~lvl;
            end else if (sync_s[i] == lvl) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + DB_W'(1);
            end
        end
    end

    logic inc_rise;
    logic inc_fall;
    assign inc_rise = db_flip[1] & ~nivel[1];
    assign inc_fall = db_flip[1] &  nivel[1];

    assign nivel_ajuste = nivel[0];
    assign nivel_inc    = nivel[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_ajuste <= 1'b0;
        end else begin
            btn_ajuste <= db_flip[0] & ~nivel[0];
        end
    end

    inc_state_t       state;
    inc_state_t       state_nxt;
    logic [RPT_W-1:0] rpt_cnt;
    logic [RPT_W-1:0] rpt_cnt_nxt;
    logic             inc_pulse_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            rpt_cnt <= '0;
            btn_inc <= 1'b0;
        end else begin
            state   <= state_nxt;
            rpt_cnt <= rpt_cnt_nxt;
            btn_inc <= inc_pulse_nxt;
        end
    end

    // Release is tested first so it always beats a coincident expiry.
    always_comb begin
        state_nxt     = state;
        rpt_cnt_nxt   = rpt_cnt;
        inc_pulse_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (inc_rise) begin
                    state_nxt     = DELAY;
                    rpt_cnt_nxt   = '0;
                    inc_pulse_nxt = 1'b1;
                end
            end
            DELAY: begin
                if (inc_fall) begin
                    state_nxt = IDLE;
                end else if (rpt_cnt >= DELAY_LAST) begin
                    if (repeat_en) begin
                        state_nxt     = REPEAT;
                        rpt_cnt_nxt   = '0;
                        inc_pulse_nxt = 1'b1;
                    end
                end else begin
                    rpt_cnt_nxt = rpt_cnt + RPT_W'(1);
                end
            end
            REPEAT: begin
                if (inc_fall) begin
                    state_nxt = IDLE;
                end else if (!repeat_en) begin
                    state_nxt = DELAY;
                end else if (rpt_cnt >= PERIOD_LAST) begin
                    rpt_cnt_nxt   = '0;
                    inc_pulse_nxt = 1'b1;
                end else begin
                    rpt_cnt_nxt = rpt_cnt + RPT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_condicionador_botoes.sv
// Bench for condicionador_botoes: window/timestamp reference model compared
// every cycle, plus literal pulse-edge lists for each directed scenario.
module tb_condicionador_botoes;
    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;
    localparam int M_IDLE   = 0;
    localparam int M_DELAY  = 1;
    localparam int M_REPEAT = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn_ajuste_raw = 1'b0;
    logic btn_inc_raw = 1'b0;
    logic repeat_en = 1'b0;
    logic btn_ajuste, btn_inc, nivel_ajuste, nivel_inc;

    int checks = 0;
    int errors = 0;
    bit armed = 0;

    condicionador_botoes #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_ajuste_raw(btn_ajuste_raw),
        .btn_inc_raw   (btn_inc_raw),
        .repeat_en     (repeat_en),
        .btn_ajuste    (btn_ajuste),
        .btn_inc       (btn_inc),
        .nivel_ajuste  (nivel_ajuste),
        .nivel_inc     (nivel_inc)
    );

    always #5 clk = ~clk;

    // Reference model: level flips after D consecutive disagreeing samples;
    // repeat pulses are scheduled from the edge number of the last pulse.
    int edge_n = 0;
    bit m_s1[2], m_s2[2], m_lvl[2];
    bit hist[2][D];
    bit raw_v[2], rise[2], fall[2];
    bit all_diff;
    int mode = M_IDLE;
    int m_start = 0;
    bit exp_aj = 0, exp_inc = 0;

    initial forever begin
        @(posedge clk or negedge reset);
        if (!reset) begin
            edge_n = 0; mode = M_IDLE; m_start = 0; exp_aj = 0; exp_inc = 0;
            for (int c = 0; c < 2; c++) begin
                m_s1[c] = 0; m_s2[c] = 0; m_lvl[c] = 0;
                for (int j = 0; j < D; j++) hist[c][j] = 0;
            end
        end else begin
            edge_n++;
            raw_v[0] = btn_ajuste_raw;
            raw_v[1] = btn_inc_raw;
            for (int c = 0; c < 2; c++) begin
                for (int j = D - 1; j > 0; j--) hist[c][j] = hist[c][j-1];
                hist[c][0] = m_s2[c];
                all_diff = 1;
                for (int j = 0; j < D; j++) if (hist[c][j] == m_lvl[c]) all_diff = 0;
                rise[c] = all_diff && !m_lvl[c];
                fall[c] = all_diff && m_lvl[c];
                if (all_diff) m_lvl[c] = !m_lvl[c];
                m_s2[c] = m_s1[c];
                m_s1[c] = raw_v[c];
            end
            exp_aj  = rise[0];
            exp_inc = 0;
            if (fall[1]) begin
                mode = M_IDLE;
            end else if (rise[1]) begin
                exp_inc = 1; mode = M_DELAY; m_start = edge_n;
            end else if (mode == M_DELAY) begin
                if (repeat_en && (edge_n - m_start >= RD)) begin
                    exp_inc = 1; mode = M_REPEAT; m_start = edge_n;
                end
            end else if (mode == M_REPEAT) begin
                if (!repeat_en) begin
                    mode = M_DELAY; m_start++;
                end else if (edge_n - m_start >= RP) begin
                    exp_inc = 1; m_start = edge_n;
                end
            end
        end
    end

    int dut_aj_q[$], dut_inc_q[$], mdl_aj_q[$], mdl_inc_q[$];
    int aj_fall_q[$], inc_fall_q[$], inc_rise_q[$];
    int exp_q[$];
    bit prev_aj_lvl = 0, prev_inc_lvl = 0;

    function automatic void check(input string nm, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at t=%0t edge %0d: got %b, required %b", nm, $time, edge_n, act, req);
        end
    endfunction

    function automatic string q2s(input int q[$]);
        string s = "";
        foreach (q[i]) s = {s, $sformatf("%0d ", q[i])};
        return s;
    endfunction

    function automatic void check_q(input string nm, input int got[$], input int req[$]);
        bit bad = 0;
        checks++;
        if (got.size() != req.size()) bad = 1;
        else foreach (got[i]) if (got[i] != req[i]) bad = 1;
        if (bad) begin
            errors++;
            $display("FAIL %s: got edges [ %s], required [ %s]", nm, q2s(got), q2s(req));
        end
    endfunction

    initial forever begin
        @(negedge clk);
        if (armed) begin
            check("btn_ajuste", btn_ajuste, exp_aj);
            check("btn_inc", btn_inc, exp_inc);
            check("nivel_ajuste", nivel_ajuste, m_lvl[0]);
            check("nivel_inc", nivel_inc, m_lvl[1]);
            if (reset && edge_n > 0) begin
                if (btn_ajuste) dut_aj_q.push_back(edge_n);
                if (btn_inc) dut_inc_q.push_back(edge_n);
                if (exp_aj) mdl_aj_q.push_back(edge_n);
                if (exp_inc) mdl_inc_q.push_back(edge_n);
                if (prev_aj_lvl && !nivel_ajuste) aj_fall_q.push_back(edge_n);
                if (prev_inc_lvl && !nivel_inc) inc_fall_q.push_back(edge_n);
                if (!prev_inc_lvl && nivel_inc) inc_rise_q.push_back(edge_n);
            end
        end
        prev_aj_lvl  = nivel_ajuste;
        prev_inc_lvl = nivel_inc;
    end

    task automatic clear_logs();
        dut_aj_q.delete(); dut_inc_q.delete(); mdl_aj_q.delete(); mdl_inc_q.delete();
        aj_fall_q.delete(); inc_fall_q.delete(); inc_rise_q.delete();
    endtask

    task automatic do_reset(input logic aj, input logic inc, input logic ren);
        @(negedge clk);
        reset = 0;
        armed = 1;
        btn_ajuste_raw = aj; btn_inc_raw = inc; repeat_en = ren;
        repeat (3) @(negedge clk);
        check("rst_btn_ajuste", btn_ajuste, 1'b0);
        check("rst_btn_inc", btn_inc, 1'b0);
        check("rst_nivel_ajuste", nivel_ajuste, 1'b0);
        check("rst_nivel_inc", nivel_inc, 1'b0);
        clear_logs();
        reset = 1;
    endtask

    task automatic wait_edge(input int n);
        for (int i = 0; i < 500 && edge_n < n; i++) @(negedge clk);
        if (edge_n < n) begin
            errors++;
            $display("FAIL wait_edge: reached edge %0d, required %0d", edge_n, n);
        end
    endtask

    initial begin
        // Held through reset: both channels press at edge 6.
        do_reset(1, 1, 0);
        wait_edge(12);
        exp_q = '{6};
        check_q("reset_aj_pulses", dut_aj_q, exp_q);
        check_q("reset_inc_pulses", dut_inc_q, exp_q);
        check_q("model_reset_inc", mdl_inc_q, exp_q);

        // Clean adjust press.
        do_reset(0, 0, 0);
        wait_edge(9);
        btn_ajuste_raw = 1;
        wait_edge(39);
        btn_ajuste_raw = 0;
        wait_edge(55);
        exp_q = '{15};
        check_q("clean_aj_pulses", dut_aj_q, exp_q);
        check_q("model_clean_aj", mdl_aj_q, exp_q);
        exp_q = '{45};
        check_q("clean_aj_fall", aj_fall_q, exp_q);
        exp_q = {};
        check_q("clean_inc_pulses", dut_inc_q, exp_q);

        // Bounce at 2- and 3-cycle periods.
        do_reset(0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            btn_inc_raw = ((i / 2) % 2) == 0;
            @(negedge clk);
        end
        btn_inc_raw = 0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 24; i++) begin
            btn_inc_raw = ((i / 3) % 2) == 0;
            @(negedge clk);
        end
        btn_inc_raw = 0;
        repeat (10) @(negedge clk);
        exp_q = {};
        check_q("bounce_inc_pulses", dut_inc_q, exp_q);
        check_q("bounce_inc_level", inc_rise_q, exp_q);

        // Auto-repeat; release lands on an expiry edge (46).
        do_reset(0, 1, 1);
        wait_edge(40);
        btn_inc_raw = 0;
        wait_edge(60);
        exp_q = '{6, 16, 19, 22, 25, 28, 31, 34, 37, 40, 43};
        check_q("repeat_inc_pulses", dut_inc_q, exp_q);
        check_q("model_repeat_inc", mdl_inc_q, exp_q);
        exp_q = '{46};
        check_q("repeat_inc_fall", inc_fall_q, exp_q);

        // Repeat disabled, then enabled while the counter sits at expiry.
        do_reset(0, 1, 0);
        wait_edge(25);
        repeat_en = 1;
        wait_edge(40);
        btn_inc_raw = 0;
        wait_edge(60);
        exp_q = '{6, 26, 29, 32, 35, 38, 41, 44};
        check_q("norepeat_inc_pulses", dut_inc_q, exp_q);
        check_q("model_norepeat_inc", mdl_inc_q, exp_q);

        // Simultaneous press, then reset while the pulses are high.
        do_reset(0, 0, 0);
        wait_edge(4);
        btn_ajuste_raw = 1;
        btn_inc_raw = 1;
        wait_edge(9);
        @(posedge clk);
        #1;
        check("simul_btn_ajuste", btn_ajuste, 1'b1);
        check("simul_btn_inc", btn_inc, 1'b1);
        reset = 0;
        #1;
        check("midrst_btn_ajuste", btn_ajuste, 1'b0);
        check("midrst_btn_inc", btn_inc, 1'b0);
        check("midrst_nivel_ajuste", nivel_ajuste, 1'b0);
        check("midrst_nivel_inc", nivel_inc, 1'b0);
        @(negedge clk);
        clear_logs();
        reset = 1;
        wait_edge(12);
        exp_q = '{6};
        check_q("afterrst_aj_pulses", dut_aj_q, exp_q);
        check_q("afterrst_inc_pulses", dut_inc_q, exp_q);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/condicionador_botoes.md
# condicionador_botoes

Conditions the two raw push-buttons of the digital clock into the clean single-cycle command pulses consumed by `Relogio_Digital` on `btn_ajuste` and `btn_inc`. Each raw input is synchronised, debounced and edge-detected. The increment channel also auto-repeats while held, so hours and minutes can be stepped quickly. The block sits between the board pins and the clock core, and is the producing end of the button command interface.

## Interface
- `DEBOUNCE_CYCLES`, default 20000: consecutive cycles a synchronised input must disagree with the debounced level before that level flips; must be ≥2.
- `REPEAT_DELAY`, default 500000: cycles from the first `btn_inc` pulse to the first auto-repeat pulse; must be ≥2.
- `REPEAT_PERIOD`, default 150000: cycles between subsequent auto-repeat pulses; must be ≥2.
- `clk` input 1: single system clock; all logic is on its rising edge.
- `reset` input 1: asynchronous, active-low reset (0 = reset asserted).
- `btn_ajuste_raw` input 1: raw adjust button, pressed = 1, asynchronous to `clk`.
- `btn_inc_raw` input 1: raw increment button, pressed = 1, asynchronous to `clk`.
- `repeat_en` input 1: enables auto-repeat on the increment channel; synchronous, quasi-static.
- `btn_ajuste` output 1: one-cycle pulse per debounced press of the adjust button.
- `btn_inc` output 1: one-cycle pulse per debounced press of the increment button, plus auto-repeat pulses.
- `nivel_ajuste` output 1: debounced level of the adjust button.
- `nivel_inc` output 1: debounced level of the increment button.

## Operation
- **Reset.** While `reset` = 0, every flop clears asynchronously: synchronisers, debounce counters, levels, pulses, the repeat counter and the FSM (state IDLE). All outputs are 0.
- **Synchroniser.** Each raw input passes through a 2-flop synchroniser; the synchronised value is `s`.
- **Debounce, per channel.**
  - Counter width is `$clog2(DEBOUNCE_CYCLES)`.
  - In any cycle where `s` equals the current level, the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter is at `DEBOUNCE_CYCLES-1` and `s` still differs, the level toggles and the counter clears, both on that edge.
- **Adjust pulse.** `btn_ajuste` is a registered pulse, set on the same edge the adjust level rises 0→1. It lasts exactly 1 cycle. A falling level produces no pulse.
- **Increment FSM (IDLE, DELAY, REPEAT).** Uses one repeat counter.
  - IDLE → DELAY on the edge the inc level rises. `btn_inc` pulses on that edge and the counter clears.
  - DELAY: the counter increments each cycle. At count `REPEAT_DELAY-1`:
    - if `repeat_en` = 1: pulse `btn_inc`, clear the counter, go to REPEAT;
    - if `repeat_en` = 0: stay in DELAY, hold the counter, no pulse.
  - REPEAT: at count `REPEAT_PERIOD-1`, pulse `btn_inc` and clear the counter. If `repeat_en` = 0, return to DELAY with the counter held.
  - DELAY or REPEAT → IDLE on the edge the inc level falls. No pulse occurs on that edge, even if the counter expires on the same edge: release wins.
- **Channel independence.** The two channels are independent. Simultaneous presses produce simultaneous pulses on both outputs, with no priority or lockout.
- **Pulse spacing.** `btn_inc` is never high for 2 consecutive cycles.

## Timing
- **Press latency.** A raw change set up before edge k makes `s` change after edge k+1. The level and the pulse change after edge k+1+`DEBOUNCE_CYCLES`. Latency is therefore `DEBOUNCE_CYCLES`+2 edges; release latency is the same.
- **Glitch rejection.** A raw glitch lasting fewer than `DEBOUNCE_CYCLES` synchronised cycles changes no output.
- **Auto-repeat timing.** With the initial press pulse on edge e and `repeat_en` = 1 throughout:
  - the first repeat pulse is on edge e+`REPEAT_DELAY`;
  - later pulses are on edge e+`REPEAT_DELAY`+n·`REPEAT_PERIOD`, for n ≥ 1.
- **Reset mid-press.**
  - Outputs drop to 0 immediately when `reset` falls, with no partial pulse.
  - If the button is still held after `reset` is released, it is treated as a new press: one pulse follows after `DEBOUNCE_CYCLES`+2 edges.
- **Synchroniser flops.** The synchroniser flops must not be combined with other logic.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=3, and release `reset` before edge 1.

- **Reset values.** Hold `reset`=0 with both raw inputs at 1 → every output is 0. Release `reset` → `nivel_*` and `btn_*` rise after edge 6; each `btn_*` is high for exactly 1 cycle.
- **Clean press.** `btn_ajuste_raw`=1 before edge 10, held for 30 cycles → exactly one `btn_ajuste` pulse, after edge 15. `nivel_ajuste` falls 6 edges after the raw input is released.
- **Bounce rejection.**
  - `btn_inc_raw` toggles every 2 cycles for 20 cycles, then stays at 0 → `nivel_inc` and `btn_inc` stay at 0.
  - Toggling every 3 cycles also produces no pulse.
- **Auto-repeat.** `repeat_en`=1, `btn_inc_raw` held from before edge 1 for 40 cycles → `btn_inc` pulses after edges 6, 16, 19, 22, 25, …, then stops once `nivel_inc` falls. Each pulse is 1 cycle wide.
- **Repeat disabled.** Same stimulus with `repeat_en`=0 → only one pulse, after edge 6. Raising `repeat_en` while still held → next pulse on the following edge (counter held at expiry), then every 3 cycles.
- **Simultaneous and release race.**
  - Both raw inputs rise together → `btn_ajuste` and `btn_inc` pulse in the same cycle.
  - Timing the release so that `nivel_inc` falls on an expiry edge → no pulse on that edge, and the FSM returns to IDLE.
